// File: rtl/dmux_xx4_reg_pkg.sv
// Shared definitions for the registered 1-to-4 stream demultiplexer.
//   LANES        : number of output lanes
//   SEL_W        : width of a lane index (i_sel, rr_ptr)
//   lane_idx_t   : lane index type
//   rr_mode_e    : lane selection policy encodings for the RR_MODE parameter
package dmux_xx4_reg_pkg;

  localparam int unsigned LANES = 4;
  localparam int unsigned SEL_W = 2;

  typedef logic [SEL_W-1:0] lane_idx_t;

  typedef enum int unsigned {
    RR_MODE_SEL = 0,  // lane taken from i_sel
    RR_MODE_RR  = 1   // lane taken from the internal round-robin pointer
  } rr_mode_e;

endpackage

// File: rtl/dmux_xx4_reg_if.sv
// Stream bundle for dmux_xx4_reg: one valid/ready input stream and four
// valid/ready output lanes.
//   i_vld/i_rdy/i_sel/i_dat : producer side
//   o_vld/o_rdy             : per-lane handshake, bit n = lane n
//   o_dat0..o_dat3          : per-lane data
// modport slave  : view of the demultiplexer itself
// modport master : view of the surrounding producer/consumers
interface dmux_xx4_reg_if
  import dmux_xx4_reg_pkg::*;
#(
  parameter int unsigned WIDTH = 1
) ();

  logic             i_vld;
  logic             i_rdy;
  lane_idx_t        i_sel;
  logic [WIDTH-1:0] i_dat;
  logic [LANES-1:0] o_vld;
  logic [LANES-1:0] o_rdy;
  logic [WIDTH-1:0] o_dat0;
  logic [WIDTH-1:0] o_dat1;
  logic [WIDTH-1:0] o_dat2;
  logic [WIDTH-1:0] o_dat3;

  modport slave (
    input  i_vld, i_sel, i_dat, o_rdy,
    output i_rdy, o_vld, o_dat0, o_dat1, o_dat2, o_dat3
  );

  modport master (
    output i_vld, i_sel, i_dat, o_rdy,
    input  i_rdy, o_vld, o_dat0, o_dat1, o_dat2, o_dat3
  );

endinterface

// File: rtl/dmux_xx4_reg_lane.sv
// One output lane of dmux_xx4_reg: a single-entry holding register with a
// valid bit.
//   clk, rst_n : clock, asynchronous active-low reset
//   flush      : synchronous clear of the valid bit (data left untouched)
//   load       : capture d, set vld
//   drain      : consumer took the entry; clears vld unless load also set
//   d, q       : data in / held data
//   vld        : entry is occupied
module dmux_lane_reg #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             load,
  input  logic             drain,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             vld
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q   <= '0;
      vld <= 1'b0;
    end else if (flush) begin
      vld <= 1'b0;
    end else if (load) begin
      // load wins over drain: back-to-back traffic keeps vld high
      q   <= d;
      vld <= 1'b1;
    end else if (drain) begin
      vld <= 1'b0;
    end
  end

endmodule

// File: rtl/dmux_xx4_reg.sv
// Registered 1-to-4 stream demultiplexer. Routes the input stream to one of
// four single-entry output lanes, chosen by i_sel or by a round-robin pointer.
//   clk, rst_n : clock, asynchronous active-low reset
//   flush      : synchronous clear of all lanes and the pointer
//   bus        : stream bundle (dmux_xx4_reg_if.slave)
//   rr_ptr     : current round-robin pointer (0 in select mode)
// Parameters: WIDTH (data width), RR_MODE (rr_mode_e encoding).
module dmux_xx4_reg
  import dmux_xx4_reg_pkg::*;
#(
  parameter int unsigned WIDTH   = 1,
  parameter int unsigned RR_MODE = RR_MODE_SEL
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  dmux_xx4_reg_if.slave        bus,
  output logic [SEL_W-1:0]     rr_ptr
);

  logic [LANES-1:0] lane_vld;
  logic [LANES-1:0] load;
  logic [LANES-1:0] drain;
  logic [WIDTH-1:0] lane_q [LANES];
  lane_idx_t        tgt;
  logic             accept;

  always_comb begin
    tgt = bus.i_sel;
    if (RR_MODE == RR_MODE_RR) begin
      tgt = rr_ptr;
    end
  end

  // Ready is combinational from o_rdy so a full lane being drained can be
  // reloaded in the same cycle. rst_n gates it so nothing is offered while
  // reset is held.
  assign bus.i_rdy = rst_n & ~flush & (~lane_vld[tgt] | bus.o_rdy[tgt]);
  assign accept    = bus.i_vld & bus.i_rdy;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    assign load[g]  = accept & (tgt == lane_idx_t'(g));
    assign drain[g] = lane_vld[g] & bus.o_rdy[g];

    dmux_lane_reg #(
      .WIDTH (WIDTH)
    ) u_lane (
      .clk   (clk),
      .rst_n (rst_n),
      .flush (flush),
      .load  (load[g]),
      .drain (drain[g]),
      .d     (bus.i_dat),
      .q     (lane_q[g]),
      .vld   (lane_vld[g])
    );
  end

  assign bus.o_vld  = lane_vld;
  assign bus.o_dat0 = lane_q[0];
  assign bus.o_dat1 = lane_q[1];
  assign bus.o_dat2 = lane_q[2];
  assign bus.o_dat3 = lane_q[3];

  if (RR_MODE == RR_MODE_RR) begin : g_rr
    // Pointer only moves on an accepted word, so a full target lane stalls
    // the stream instead of skipping ahead: lane order stays strict.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rr_ptr <= '0;
      end else if (flush) begin
        rr_ptr <= '0;
      end else if (accept) begin
        rr_ptr <= rr_ptr + SEL_W'(1);
      end
    end
  end else begin : g_sel
    assign rr_ptr = '0;
  end

endmodule

// File: tb/tb_dmux_xx4_reg.sv
// Self-checking bench for dmux_xx4_reg. Two instances (select mode and
// round-robin mode, WIDTH=8) receive identical stimulus; a per-lane
// occupancy/data model checks both every cycle, with directed vectors and
// hand sequences adding explicit expected values.
module tb_dmux_xx4_reg;
  import dmux_xx4_reg_pkg::*;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       flush = 1'b0;
  logic [1:0] ptr_a;
  logic [1:0] ptr_b;

  dmux_xx4_reg_if #(.WIDTH(8)) ifa ();
  dmux_xx4_reg_if #(.WIDTH(8)) ifb ();

  dmux_xx4_reg #(.WIDTH(8), .RR_MODE(RR_MODE_SEL)) dut_a (
    .clk    (clk),
    .rst_n  (rst_n),
    .flush  (flush),
    .bus    (ifa),
    .rr_ptr (ptr_a)
  );

  dmux_xx4_reg #(.WIDTH(8), .RR_MODE(RR_MODE_RR)) dut_b (
    .clk    (clk),
    .rst_n  (rst_n),
    .flush  (flush),
    .bus    (ifb),
    .rr_ptr (ptr_b)
  );

  always #5 clk = ~clk;

  int unsigned errors = 0;
  int unsigned checks = 0;

  // reference: occupancy, contents and pointer per instance (0=sel, 1=rr)
  logic [3:0]  mv [2];
  logic [7:0]  md [2][4];
  int unsigned mp [2];

  logic       s_vld;
  logic [1:0] s_sel;
  logic [7:0] s_dat;
  logic [3:0] s_ordy;
  logic       s_flush;
  logic       obs_rdy_a;
  logic       obs_rdy_b;

  typedef struct {
    logic        vld;
    logic [1:0]  sel;
    logic [7:0]  dat;
    logic [3:0]  ordy;
    logic        fl;
    logic        exp_rdy;
    logic [3:0]  exp_vld;
    logic [31:0] exp_dat;
  } vec_t;

  vec_t tbl [9];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic model_rdy(input int d);
    logic [1:0] t;
    t = (d == 1) ? 2'(mp[d]) : s_sel;
    return rst_n && !s_flush && (!mv[d][t] || s_ordy[t]);
  endfunction

  function automatic void model_update(input int d, input logic rdy);
    logic [1:0] t;
    if (s_flush) begin
      mv[d] = '0;
      mp[d] = 0;
    end else begin
      t = (d == 1) ? 2'(mp[d]) : s_sel;
      for (int n = 0; n < 4; n++)
        if (mv[d][n] && s_ordy[n]) mv[d][n] = 1'b0;
      if (s_vld && rdy) begin
        mv[d][t] = 1'b1;
        md[d][t] = s_dat;
        if (d == 1) mp[d] = (mp[d] + 1) % 4;
      end
    end
  endfunction

  function automatic void model_reset();
    for (int d = 0; d < 2; d++) begin
      mv[d] = '0;
      mp[d] = 0;
      for (int n = 0; n < 4; n++) md[d][n] = '0;
    end
  endfunction

  function automatic logic [31:0] dat_a();
    return {ifa.o_dat3, ifa.o_dat2, ifa.o_dat1, ifa.o_dat0};
  endfunction

  function automatic logic [31:0] dat_b();
    return {ifb.o_dat3, ifb.o_dat2, ifb.o_dat1, ifb.o_dat0};
  endfunction

  function automatic logic [7:0] lane_b(input int n);
    logic [31:0] w;
    w = dat_b();
    return w[n*8 +: 8];
  endfunction

  task automatic check_outputs();
    chk("o_vld_a", 32'(ifa.o_vld), 32'(mv[0]));
    chk("o_dat_a", dat_a(), {md[0][3], md[0][2], md[0][1], md[0][0]});
    chk("rr_ptr_a", 32'(ptr_a), mp[0]);
    chk("o_vld_b", 32'(ifb.o_vld), 32'(mv[1]));
    chk("o_dat_b", dat_b(), {md[1][3], md[1][2], md[1][1], md[1][0]});
    chk("rr_ptr_b", 32'(ptr_b), mp[1]);
  endtask

  task automatic drive(input logic vld, input logic [1:0] sel, input logic [7:0] dat,
                       input logic [3:0] ordy, input logic fl);
    s_vld = vld; s_sel = sel; s_dat = dat; s_ordy = ordy; s_flush = fl;
    ifa.i_vld = vld; ifa.i_sel = sel; ifa.i_dat = dat; ifa.o_rdy = ordy;
    ifb.i_vld = vld; ifb.i_sel = sel; ifb.i_dat = dat; ifb.o_rdy = ordy;
    flush = fl;
  endtask

  // one clock: drive, check ready before the edge, check state after it
  task automatic step(input logic vld, input logic [1:0] sel, input logic [7:0] dat,
                      input logic [3:0] ordy, input logic fl);
    logic ra, rb;
    drive(vld, sel, dat, ordy, fl);
    #1;
    ra = model_rdy(0);
    rb = model_rdy(1);
    obs_rdy_a = ifa.i_rdy;
    obs_rdy_b = ifb.i_rdy;
    chk("i_rdy_a", 32'(obs_rdy_a), 32'(ra));
    chk("i_rdy_b", 32'(obs_rdy_b), 32'(rb));
    @(posedge clk);
    #1;
    model_update(0, ra);
    model_update(1, rb);
    check_outputs();
  endtask

  // async reset asserted between edges, checked before any clock edge
  task automatic reset_check();
    drive(1'b1, 2'd1, 8'hFF, 4'h0, 1'b0);
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst_o_vld_a", 32'(ifa.o_vld), 32'h0);
    chk("rst_o_dat_a", dat_a(), 32'h0);
    chk("rst_o_vld_b", 32'(ifb.o_vld), 32'h0);
    chk("rst_o_dat_b", dat_b(), 32'h0);
    chk("rst_rr_ptr_b", 32'(ptr_b), 32'h0);
    chk("rst_i_rdy_a", 32'(ifa.i_rdy), 32'h0);
    chk("rst_i_rdy_b", 32'(ifb.i_rdy), 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive(1'b0, 2'd0, 8'h00, 4'hF, 1'b0);
  endtask

  localparam logic [3:0] RR_VLD [6] = '{4'b0001, 4'b0010, 4'b0100, 4'b1100, 4'b0101, 4'b0110};

  initial begin
    model_reset();
    drive(1'b0, 2'd0, 8'h00, 4'hF, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    reset_check();

    // directed select-mode vectors against instance A (starting from reset)
    tbl[0] = '{1'b1, 2'd2, 8'h11, 4'hF, 1'b0, 1'b1, 4'b0100, 32'h0011_0000};
    tbl[1] = '{1'b0, 2'd0, 8'h00, 4'hF, 1'b0, 1'b1, 4'b0000, 32'h0011_0000};
    tbl[2] = '{1'b1, 2'd1, 8'h22, 4'h0, 1'b0, 1'b1, 4'b0010, 32'h0011_2200};
    tbl[3] = '{1'b1, 2'd1, 8'h33, 4'h0, 1'b0, 1'b0, 4'b0010, 32'h0011_2200};
    tbl[4] = '{1'b1, 2'd3, 8'h44, 4'h0, 1'b0, 1'b1, 4'b1010, 32'h4411_2200};
    tbl[5] = '{1'b1, 2'd0, 8'h5A, 4'h0, 1'b0, 1'b1, 4'b1011, 32'h4411_225A};
    tbl[6] = '{1'b1, 2'd0, 8'hA5, 4'h1, 1'b0, 1'b1, 4'b1011, 32'h4411_22A5};
    tbl[7] = '{1'b1, 2'd2, 8'h66, 4'h0, 1'b1, 1'b0, 4'b0000, 32'h4411_22A5};
    tbl[8] = '{1'b0, 2'd0, 8'h00, 4'hF, 1'b0, 1'b1, 4'b0000, 32'h4411_22A5};
    for (int i = 0; i < 9; i++) begin
      step(tbl[i].vld, tbl[i].sel, tbl[i].dat, tbl[i].ordy, tbl[i].fl);
      chk($sformatf("tbl%0d_rdy", i), 32'(obs_rdy_a), 32'(tbl[i].exp_rdy));
      chk($sformatf("tbl%0d_vld", i), 32'(ifa.o_vld), 32'(tbl[i].exp_vld));
      chk($sformatf("tbl%0d_dat", i), dat_a(), tbl[i].exp_dat);
    end

    // round robin: words 0..5, lane 2 stops draining once loaded
    step(1'b0, 2'd0, 8'h00, 4'hF, 1'b1);
    for (int k = 0; k < 6; k++) begin
      step(1'b1, 2'd0, 8'(k), (k < 2) ? 4'hF : 4'b1011, 1'b0);
      chk($sformatf("rr%0d_vld", k), 32'(ifb.o_vld), 32'(RR_VLD[k]));
      chk($sformatf("rr%0d_dat", k), 32'(lane_b(k % 4)), k);
      chk($sformatf("rr%0d_ptr", k), 32'(ptr_b), (k + 1) % 4);
    end
    for (int k = 0; k < 2; k++) begin
      step(1'b1, 2'd0, 8'h06, 4'b1011, 1'b0);
      chk("rr_stall_rdy", 32'(obs_rdy_b), 32'h0);
      chk("rr_stall_ptr", 32'(ptr_b), 32'd2);
      chk("rr_stall_vld", 32'(ifb.o_vld), 32'b0100);
    end

    // flush with all lanes full and rr_ptr=3
    step(1'b0, 2'd0, 8'h00, 4'hF, 1'b1);
    for (int k = 0; k < 4; k++) step(1'b1, 2'(k), 8'(8'h80 + k), 4'h0, 1'b0);
    step(1'b0, 2'd0, 8'h00, 4'b0111, 1'b0);
    for (int k = 0; k < 3; k++) step(1'b1, 2'(k), 8'(8'h90 + k), 4'h0, 1'b0);
    chk("fl_pre_vld", 32'(ifb.o_vld), 32'hF);
    chk("fl_pre_ptr", 32'(ptr_b), 32'd3);
    step(1'b1, 2'd0, 8'h77, 4'h0, 1'b1);
    chk("fl_rdy", 32'(obs_rdy_b), 32'h0);
    chk("fl_vld", 32'(ifb.o_vld), 32'h0);
    chk("fl_ptr", 32'(ptr_b), 32'h0);
    chk("fl_dat", dat_b(), 32'h8392_9190);
    step(1'b0, 2'd0, 8'h00, 4'h0, 1'b0);
    chk("fl_after_vld", 32'(ifb.o_vld), 32'h0);

    // randomized traffic against the model
    for (int k = 0; k < 400; k++) begin
      step(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 8'($urandom),
           4'($urandom), 1'($urandom_range(0, 15) == 0));
    end

    // load up lanes, then reset mid-traffic
    for (int k = 0; k < 4; k++) step(1'b1, 2'(k), 8'(8'hC0 + k), 4'h0, 1'b0);
    reset_check();
    step(1'b1, 2'd2, 8'h11, 4'hF, 1'b0);
    chk("post_rst_vld_a", 32'(ifa.o_vld), 32'b0100);
    chk("post_rst_vld_b", 32'(ifb.o_vld), 32'b0001);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
